uart_rx_frontend: RTL and testbench

//  Receive-side line front end for the UART receiver control FSM.
//  - Synchronises and de-glitches the raw RX pin.
//  - Detects the start-bit falling edge (rx_pin_H2L).
//  - Generates the mid-bit sample strobe (rx_clk_bps) while the control FSM holds rx_band_sig.

---
 rtl/uart_pkg.sv | 24 ++
 rtl/uart_bps_gen.sv | 42 ++++
 rtl/uart_rx_frontend.sv | 66 ++++++
 tb/tb_uart_rx_frontend.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: default line rate, idle level and the baud divider helper.
// Used by both the RX and TX paths.
package uart_pkg;

   localparam int   DEF_CLK_FREQ = 50_000_000;
   localparam int   DEF_BAUD     = 9600;
   localparam logic LINE_IDLE    = 1'b1;

   // Registered state of the filtered line and its start-edge detector.
   typedef struct packed {
      logic level;
      logic prev;
      logic fall;
   } rx_line_t;

   function automatic int bps_cnt(input int clk_freq, input int baud);
      return clk_freq / baud;
   endfunction

   function automatic logic maj3(input logic a, input logic b, input logic c);
      return (a & b) | (a & c) | (b & c);
   endfunction

endpackage

// File: rtl/uart_bps_gen.sv
// Baud counter: runs while run is high, emits a one-cycle tick at a fixed phase.
// HALF = 0 puts the tick on the wrap, which is what the TX side uses.
module uart_bps_gen
   import uart_pkg::*;
#(
   parameter int BPS_CNT = 10,
   parameter int HALF    = 5
) (
   input  logic clk,
   input  logic rst_n,
   input  logic run,
   output logic tick
);

   localparam int CW = (BPS_CNT > 1) ? $clog2(BPS_CNT) : 1;
   localparam logic [CW-1:0] LAST    = CW'(BPS_CNT - 1);
   localparam logic [CW-1:0] TICK_AT = (HALF == 0) ? LAST : CW'(HALF - 1);

   if (BPS_CNT < 4) begin : g_bad_bps
      $error("uart_bps_gen: BPS_CNT must be at least 4");
   end
   if (HALF >= BPS_CNT) begin : g_bad_half
      $error("uart_bps_gen: HALF must be below BPS_CNT");
   end

   logic [CW-1:0] cnt;

   // Dropping run clears the phase, so a restart always counts from zero.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt  <= '0;
         tick <= 1'b0;
      end else if (!run) begin
         cnt  <= '0;
         tick <= 1'b0;
      end else begin
         cnt  <= (cnt == LAST) ? '0 : cnt + CW'(1);
         tick <= (cnt == TICK_AT);
      end
   end

endmodule

// File: rtl/uart_rx_frontend.sv
// RX line front end: synchroniser, 3-tap majority filter, start-edge detect and
// the mid-bit sample strobe that drive the RX control FSM.
module uart_rx_frontend
   import uart_pkg::*;
#(
   parameter int CLK_FREQ    = DEF_CLK_FREQ,
   parameter int BAUD        = DEF_BAUD,
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic rx_pin,
   input  logic rx_band_sig,
   output logic rx_pin_in,
   output logic rx_pin_H2L,
   output logic rx_clk_bps
);

   localparam int BPS_CNT = bps_cnt(CLK_FREQ, BAUD);
   localparam int HALF    = BPS_CNT / 2;

   if (SYNC_STAGES < 2) begin : g_bad_sync
      $error("uart_rx_frontend: SYNC_STAGES must be at least 2");
   end
   if (BPS_CNT < 4) begin : g_bad_bps
      $error("uart_rx_frontend: CLK_FREQ/BAUD must be at least 4");
   end

   logic [SYNC_STAGES-1:0] sync;
   logic [1:0]             taps;
   logic                   synced;
   rx_line_t               line;

   // The last synchroniser flop doubles as the newest filter tap, which keeps
   // pin-to-level latency at SYNC_STAGES + 2.
   assign synced = sync[SYNC_STAGES-1];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync <= {SYNC_STAGES{LINE_IDLE}};
         taps <= {2{LINE_IDLE}};
         line <= '{level: LINE_IDLE, prev: LINE_IDLE, fall: 1'b0};
      end else begin
         sync       <= {sync[SYNC_STAGES-2:0], rx_pin};
         taps       <= {taps[0], synced};
         line.level <= maj3(synced, taps[0], taps[1]);
         line.prev  <= line.level;
         // Data-bit edges inside a frame must not look like a new start bit.
         line.fall  <= line.prev & ~line.level & ~rx_band_sig;
      end
   end

   assign rx_pin_in  = line.level;
   assign rx_pin_H2L = line.fall;

   uart_bps_gen #(
      .BPS_CNT(BPS_CNT),
      .HALF   (HALF)
   ) u_bps (
      .clk  (clk),
      .rst_n(rst_n),
      .run  (rx_band_sig),
      .tick (rx_clk_bps)
   );

endmodule

// File: tb/tb_uart_rx_frontend.sv
// Bench for uart_rx_frontend: directed scenarios plus random line/band traffic,
// every cycle compared against a sample-history reference model.
module tb_uart_rx_frontend;

   localparam int CLK_FREQ = 1000;
   localparam int BAUD     = 100;
   localparam int SYNC     = 2;
   localparam int BPS      = CLK_FREQ / BAUD;
   localparam int HALF     = BPS / 2;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic rx_pin = 1'b1;
   logic rx_band_sig = 1'b0;
   logic rx_pin_in, rx_pin_H2L, rx_clk_bps;

   int checks = 0;
   int failures = 0;
   int step_no = 0;

   // Reference model: pin samples (newest first), filtered levels, band run length.
   logic pin_hist[$];
   logic lvl1, lvl2, m_fall, m_bps;
   int   run_len;

   int n_low, n_h2l, n_bps, first_low, first_h2l;
   int bps_steps[$];

   uart_rx_frontend #(
      .CLK_FREQ   (CLK_FREQ),
      .BAUD       (BAUD),
      .SYNC_STAGES(SYNC)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .rx_pin     (rx_pin),
      .rx_band_sig(rx_band_sig),
      .rx_pin_in  (rx_pin_in),
      .rx_pin_H2L (rx_pin_H2L),
      .rx_clk_bps (rx_clk_bps)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      pin_hist = '{1'b1, 1'b1, 1'b1, 1'b1};
      lvl1 = 1'b1; lvl2 = 1'b1; m_fall = 1'b0; m_bps = 1'b0; run_len = 0;
   endtask

   // Level after edge n is the majority of the pin samples taken at edges
   // n-2, n-3, n-4; a fall needs level(n-2)=1, level(n-1)=0 and band low at n.
   // The strobe fires when the current band-high run reaches HALF (mod BPS).
   task automatic model_edge(input logic p, input logic b);
      int ones;
      logic nl;
      ones = int'(pin_hist[1]) + int'(pin_hist[2]) + int'(pin_hist[3]);
      nl = (ones >= 2);
      m_fall = lvl2 & ~lvl1 & ~b;
      run_len = b ? run_len + 1 : 0;
      m_bps = b && (run_len % BPS == HALF);
      lvl2 = lvl1;
      lvl1 = nl;
      pin_hist.push_front(p);
      void'(pin_hist.pop_back());
   endtask

   task automatic clear_stats();
      n_low = 0; n_h2l = 0; n_bps = 0; first_low = -1; first_h2l = -1;
      bps_steps.delete();
   endtask

   task automatic step(input logic p, input logic b);
      rx_pin = p;
      rx_band_sig = b;
      @(posedge clk);
      model_edge(p, b);
      @(negedge clk);
      step_no++;
      chk("level", rx_pin_in, lvl1);
      chk("h2l", rx_pin_H2L, m_fall);
      chk("bps", rx_clk_bps, m_bps);
      if (rx_pin_in === 1'b0) begin
         n_low++;
         if (first_low < 0) first_low = step_no;
      end
      if (rx_pin_H2L === 1'b1) begin
         n_h2l++;
         if (first_h2l < 0) first_h2l = step_no;
      end
      if (rx_clk_bps === 1'b1) begin
         n_bps++;
         bps_steps.push_back(step_no);
      end
   endtask

   task automatic run(input logic p, input logic b, input int n);
      for (int i = 0; i < n; i++) step(p, b);
   endtask

   initial begin
      int t;
      int d;
      logic p;
      logic b;
      int len;

      model_reset();
      @(negedge clk);
      chk("reset_level", rx_pin_in, 1'b1);
      chk("reset_h2l", rx_pin_H2L, 1'b0);
      chk("reset_bps", rx_clk_bps, 1'b0);
      rst_n = 1'b1;

      // Line falls right after reset: level low at cycle 4, one H2L at cycle 5.
      step_no = 0;
      clear_stats();
      run(1'b0, 1'b0, 10);
      chk("t1_first_low", first_low, 4);
      chk("t1_h2l_cycle", first_h2l, 5);
      chk("t1_h2l_count", n_h2l, 1);

      // Start bit, band registered one cycle after H2L, ten bit strobes.
      run(1'b1, 1'b0, 8);
      clear_stats();
      for (int i = 0; i < 12 && first_h2l < 0; i++) step(1'b0, 1'b0);
      chk("t2_start_seen", (first_h2l >= 0), 1'b1);
      t = first_h2l;
      step(1'b0, 1'b0);
      clear_stats();
      for (int i = 0; i < 99; i++) step(logic'($urandom_range(0, 1)), 1'b1);
      chk("t2_strobe_count", n_bps, 10);
      for (int k = 0; k < bps_steps.size(); k++)
         chk("t2_strobe_offset", bps_steps[k] - t, HALF + 1 + BPS * k);
      run(1'b1, 1'b0, 8);

      // Single-cycle glitch is filtered; a two-cycle low passes as one edge.
      clear_stats();
      step(1'b0, 1'b0);
      run(1'b1, 1'b0, 8);
      chk("t3_glitch_low", n_low, 0);
      chk("t3_glitch_h2l", n_h2l, 0);
      clear_stats();
      run(1'b0, 1'b0, 2);
      run(1'b1, 1'b0, 8);
      chk("t3_pulse_low", n_low, 2);
      chk("t3_pulse_h2l", n_h2l, 1);

      // Abort at cnt=7, then restart with no residual phase.
      run(1'b1, 1'b1, 7);
      clear_stats();
      run(1'b1, 1'b0, 3);
      chk("t4_abort_bps", n_bps, 0);
      clear_stats();
      d = step_no + 1;
      run(1'b1, 1'b1, 8);
      chk("t4_restart_count", n_bps, 1);
      if (bps_steps.size() > 0)
         chk("t4_restart_offset", bps_steps[0] - (d - 1), HALF);
      run(1'b1, 1'b0, 4);

      // Line toggling inside a frame never flags a start edge.
      clear_stats();
      for (int i = 0; i < 30; i++) step(logic'((i / 2) % 2 == 0), 1'b1);
      chk("t5_h2l_in_frame", n_h2l, 0);
      run(1'b1, 1'b0, 8);

      // Asynchronous reset mid-frame, then a clean restart.
      run(1'b1, 1'b1, 3);
      #2 rst_n = 1'b0;
      #1;
      chk("t6_async_level", rx_pin_in, 1'b1);
      chk("t6_async_h2l", rx_pin_H2L, 1'b0);
      chk("t6_async_bps", rx_clk_bps, 1'b0);
      model_reset();
      @(posedge clk);
      @(negedge clk);
      chk("t6_held_bps", rx_clk_bps, 1'b0);
      rst_n = 1'b1;
      clear_stats();
      d = step_no + 1;
      run(1'b1, 1'b1, 8);
      chk("t6_restart_count", n_bps, 1);
      if (bps_steps.size() > 0)
         chk("t6_restart_offset", bps_steps[0] - d, HALF - 1);
      run(1'b1, 1'b0, 4);

      // Random traffic: sticky line with glitches, random band runs.
      p = 1'b1;
      for (int s = 0; s < 40; s++) begin
         len = $urandom_range(1, 25);
         b = logic'($urandom_range(0, 1));
         for (int j = 0; j < len; j++) begin
            if ($urandom_range(0, 3) == 0) p = ~p;
            step(p, b);
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
